basket_controller: RTL and testbench

Holds the shopping basket fed by the sale-terminal state machine. Accepts add requests (product ID + quantity) after barcode/interactive selection, merges duplicates, and appends new lines. In basket-edit mode it moves a highlight cursor and cancels the highlighted line with list compaction. Exposes a random-access read port for the VGA basket list.

---
 rtl/basket_pkg.sv | 28 ++
 rtl/basket_controller_price_rom.sv | 38 +++
 rtl/basket_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_basket_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/basket_pkg.sv
// Shared types and defaults for the sale-terminal basket controller.
package basket_pkg;

    // Controller states; clearing the basket is handled from any state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        COMPACT = 2'd2
    } basket_state_t;

    // Encodings on Dir_in.
    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Default geometry.
    localparam int BASKET_DEPTH = 8;
    localparam int BASKET_ID_W  = 4;
    localparam int BASKET_QTY_W = 3;

    // One basket line at the default geometry.
    typedef struct packed {
        logic [BASKET_ID_W-1:0]  id;
        logic [BASKET_QTY_W-1:0] qty;
    } basket_line_t;

endpackage

// File: rtl/basket_controller_price_rom.sv
// Product price lookup: product ID -> 8-bit unit price, purely combinational.
// Only instantiated when BASKET_TOTAL_EN is defined.
module product_price_rom #(
    parameter int ID_W = 4
) (
    input  logic [ID_W-1:0] id,
    output logic [7:0]      price
);

    logic [3:0] addr;

    assign addr = 4'(id);

    // Fixed price table indexed by the low product-ID bits.
    always_comb begin
        price = 8'd0;
        case (addr)
            4'd0:  price = 8'd12;
            4'd1:  price = 8'd25;
            4'd2:  price = 8'd7;
            4'd3:  price = 8'd40;
            4'd4:  price = 8'd99;
            4'd5:  price = 8'd15;
            4'd6:  price = 8'd60;
            4'd7:  price = 8'd3;
            4'd8:  price = 8'd120;
            4'd9:  price = 8'd45;
            4'd10: price = 8'd80;
            4'd11: price = 8'd9;
            4'd12: price = 8'd200;
            4'd13: price = 8'd33;
            4'd14: price = 8'd18;
            4'd15: price = 8'd255;
            default: price = 8'd0;
        endcase
    end

endmodule

// File: rtl/basket_controller.sv
// Shopping basket: merges/appends added products, cursor-driven line cancel
// with compaction, and a combinational read port for the VGA list.
// Optional running total price: define BASKET_TOTAL_EN.
module basket_controller
    import basket_pkg::*;
#(
    parameter int DEPTH = BASKET_DEPTH,
    parameter int ID_W  = BASKET_ID_W,
    parameter int QTY_W = BASKET_QTY_W
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic                       Add_Pulse,
    input  logic [ID_W-1:0]            Add_ProductID,
    input  logic [QTY_W-1:0]           Add_Quantity,
    input  logic                       Cancel_Pulse,
    input  logic                       Dir_Pulse,
    input  logic [1:0]                 Dir_in,
    input  logic                       Clear_Pulse,
    input  logic [$clog2(DEPTH)-1:0]   Rd_Idx,
    output logic [ID_W-1:0]            Rd_ProductID,
    output logic [QTY_W-1:0]           Rd_Quantity,
    output logic [$clog2(DEPTH+1)-1:0] Entry_Count,
    output logic [$clog2(DEPTH)-1:0]   Highlight_Idx,
    output logic                       Busy,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Add_Ack,
    output logic                       Add_Reject
`ifdef BASKET_TOTAL_EN
    ,
    output logic [13:0]                Total_Price
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Saturating quantity add: a line never wraps past the largest quantity.
    function automatic logic [QTY_W-1:0] sat_add(input logic [QTY_W-1:0] a,
                                                 input logic [QTY_W-1:0] b);
        logic [QTY_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[QTY_W] ? {QTY_W{1'b1}} : s[QTY_W-1:0];
    endfunction

    basket_state_t state, next_state;

    logic [ID_W-1:0]  line_id  [DEPTH];
    logic [QTY_W-1:0] line_qty [DEPTH];
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] highlight;
    logic [CNT_W-1:0] scan_idx;
    logic [IDX_W-1:0] scan_lo;
    logic [IDX_W-1:0] count_lo;
    logic [ID_W-1:0]  add_id;
    logic [QTY_W-1:0] add_qty;
    logic             ack_q, reject_q;

    logic start_add, reject_now, start_cancel, dir_up, dir_down;
    logic do_append, do_merge, search_reject, scan_advance;
    logic compact_shift, compact_last;
    logic [CNT_W-1:0] hl_limit;
    logic [QTY_W-1:0] merged_qty;
    logic             rd_valid;

    // The scan index only addresses a line while it is below count.
    assign scan_lo    = scan_idx[IDX_W-1:0];
    assign count_lo   = count[IDX_W-1:0];
    assign merged_qty = sat_add(line_qty[scan_lo], add_qty);
    // Largest legal cursor once a line has been removed.
    assign hl_limit   = (count > CNT_W'(1)) ? count - CNT_W'(2) : '0;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and per-cycle decisions; Clear overrides everything.
    always_comb begin
        next_state    = state;
        start_add     = 1'b0;
        reject_now    = 1'b0;
        start_cancel  = 1'b0;
        dir_up        = 1'b0;
        dir_down      = 1'b0;
        do_append     = 1'b0;
        do_merge      = 1'b0;
        search_reject = 1'b0;
        scan_advance  = 1'b0;
        compact_shift = 1'b0;
        compact_last  = 1'b0;
        if (Clear_Pulse) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Add_Pulse) begin
                        if (Add_Quantity == '0) begin
                            reject_now = 1'b1;
                        end else begin
                            start_add  = 1'b1;
                            next_state = SEARCH;
                        end
                    end else if (Cancel_Pulse) begin
                        if (count != '0) begin
                            start_cancel = 1'b1;
                            next_state   = COMPACT;
                        end
                    end else if (Dir_Pulse) begin
                        case (Dir_in)
                            DIR_UP:    dir_up   = 1'b1;
                            DIR_DOWN:  dir_down = 1'b1;
                            DIR_LEFT,
                            DIR_RIGHT: ;
                        endcase
                    end
                end
                SEARCH: begin
                    if (scan_idx == count) begin
                        if (count < CNT_W'(DEPTH)) do_append     = 1'b1;
                        else                       search_reject = 1'b1;
                        next_state = IDLE;
                    end else if (line_id[scan_lo] == add_id) begin
                        do_merge   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        scan_advance = 1'b1;
                    end
                end
                COMPACT: begin
                    if (scan_idx == count - CNT_W'(1)) begin
                        compact_last = 1'b1;
                        next_state   = IDLE;
                    end else begin
                        compact_shift = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Basket contents, cursor, scan pointer and response pulses.
    always_ff @(posedge CLOCK_50) begin
        if (RESET || Clear_Pulse) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_id[i]  <= '0;
                line_qty[i] <= '0;
            end
            count     <= '0;
            highlight <= '0;
            scan_idx  <= '0;
            add_id    <= '0;
            add_qty   <= '0;
            ack_q     <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            ack_q    <= do_append | do_merge;
            reject_q <= reject_now | search_reject;
            if (start_add) begin
                add_id   <= Add_ProductID;
                add_qty  <= Add_Quantity;
                scan_idx <= '0;
            end
            if (start_cancel) scan_idx <= CNT_W'(highlight);
            if (scan_advance) scan_idx <= scan_idx + CNT_W'(1);
            if (dir_up && highlight != '0) highlight <= highlight - IDX_W'(1);
            if (dir_down && (CNT_W'(highlight) + CNT_W'(1)) < count)
                highlight <= highlight + IDX_W'(1);
            if (do_append) begin
                line_id[count_lo]  <= add_id;
                line_qty[count_lo] <= add_qty;
                count              <= count + CNT_W'(1);
            end
            if (do_merge) line_qty[scan_lo] <= merged_qty;
            if (compact_shift) begin
                line_id[scan_lo]  <= line_id[scan_lo + IDX_W'(1)];
                line_qty[scan_lo] <= line_qty[scan_lo + IDX_W'(1)];
                scan_idx          <= scan_idx + CNT_W'(1);
            end
            if (compact_last) begin
                line_id[scan_lo]  <= '0;
                line_qty[scan_lo] <= '0;
                count             <= count - CNT_W'(1);
                if (CNT_W'(highlight) > hl_limit) highlight <= hl_limit[IDX_W-1:0];
            end
        end
    end

`ifdef BASKET_TOTAL_EN
    logic [ID_W-1:0]  rom_id;
    logic [7:0]       price;
    logic [QTY_W-1:0] added_qty;
    logic [13:0]      total;

    // Adds are priced while searching; a cancel is priced from the cursor line.
    assign rom_id    = (state == SEARCH) ? add_id : line_id[highlight];
    assign added_qty = do_append ? add_qty : merged_qty - line_qty[scan_lo];

    product_price_rom #(.ID_W(ID_W)) u_price_rom (
        .id    (rom_id),
        .price (price)
    );

    // Running total follows every line write and every cancel start.
    always_ff @(posedge CLOCK_50) begin
        if (RESET || Clear_Pulse) begin
            total <= '0;
        end else if (do_append || do_merge) begin
            total <= total + 14'(price) * 14'(added_qty);
        end else if (start_cancel) begin
            total <= total - 14'(price) * 14'(line_qty[highlight]);
        end
    end

    assign Total_Price = total;
`endif

    assign rd_valid      = CNT_W'(Rd_Idx) < count;
    assign Rd_ProductID  = rd_valid ? line_id[Rd_Idx]  : '0;
    assign Rd_Quantity   = rd_valid ? line_qty[Rd_Idx] : '0;
    assign Entry_Count   = count;
    assign Highlight_Idx = highlight;
    assign Busy          = (state != IDLE);
    assign Full          = (count == CNT_W'(DEPTH));
    assign Empty         = (count == '0);
    assign Add_Ack       = ack_q;
    assign Add_Reject    = reject_q;

endmodule

// File: tb/tb_basket_controller.sv
// Directed, table-driven bench for basket_controller (default build).
module tb_basket_controller;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1;
    logic       Add_Pulse = 1'b0;
    logic [3:0] Add_ProductID = '0;
    logic [2:0] Add_Quantity = '0;
    logic       Cancel_Pulse = 1'b0;
    logic       Dir_Pulse = 1'b0;
    logic [1:0] Dir_in = '0;
    logic       Clear_Pulse = 1'b0;
    logic [2:0] Rd_Idx = '0;
    logic [3:0] Rd_ProductID;
    logic [2:0] Rd_Quantity;
    logic [3:0] Entry_Count;
    logic [2:0] Highlight_Idx;
    logic       Busy, Full, Empty, Add_Ack, Add_Reject;

    int checks = 0;
    int failures = 0;

    basket_controller dut (
        .CLOCK_50      (CLOCK_50),
        .RESET         (RESET),
        .Add_Pulse     (Add_Pulse),
        .Add_ProductID (Add_ProductID),
        .Add_Quantity  (Add_Quantity),
        .Cancel_Pulse  (Cancel_Pulse),
        .Dir_Pulse     (Dir_Pulse),
        .Dir_in        (Dir_in),
        .Clear_Pulse   (Clear_Pulse),
        .Rd_Idx        (Rd_Idx),
        .Rd_ProductID  (Rd_ProductID),
        .Rd_Quantity   (Rd_Quantity),
        .Entry_Count   (Entry_Count),
        .Highlight_Idx (Highlight_Idx),
        .Busy          (Busy),
        .Full          (Full),
        .Empty         (Empty),
        .Add_Ack       (Add_Ack),
        .Add_Reject    (Add_Reject)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic add;  int id; int qty;
        logic cancel; logic dirp; int dir; logic clr; int rd;
        int e_cnt; int e_hl; logic e_busy; logic e_ack; logic e_rej;
        int e_rid; int e_rqty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic add, input int id, input int qty,
                                input logic cancel, input logic dirp, input int dir,
                                input logic clr, input int rd,
                                input int cnt, input int hl, input logic busy,
                                input logic ack, input logic rej,
                                input int rid, input int rqty);
        vec_t v;
        v.add = add; v.id = id; v.qty = qty; v.cancel = cancel; v.dirp = dirp;
        v.dir = dir; v.clr = clr; v.rd = rd; v.e_cnt = cnt; v.e_hl = hl;
        v.e_busy = busy; v.e_ack = ack; v.e_rej = rej; v.e_rid = rid; v.e_rqty = rqty;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle_inputs();
        Add_Pulse = 1'b0; Cancel_Pulse = 1'b0; Dir_Pulse = 1'b0; Clear_Pulse = 1'b0;
    endtask

    task automatic do_add(input int id, input int qty, output logic ack, output logic rej);
        int waited;
        Add_Pulse = 1'b1; Add_ProductID = 4'(id); Add_Quantity = 3'(qty);
        step();
        Add_Pulse = 1'b0;
        waited = 0;
        while (!Add_Ack && !Add_Reject && waited < 20) begin
            step();
            waited++;
        end
        ack = Add_Ack;
        rej = Add_Reject;
        checks++;
        if (!ack && !rej) begin
            failures++;
            $display("FAIL add_timeout id=%0d no response after %0d cycles, required ack or reject", id, waited);
        end
    endtask

    task automatic dir_step(input logic [1:0] d);
        Dir_Pulse = 1'b1; Dir_in = d;
        step();
        Dir_Pulse = 1'b0;
    endtask

    task automatic cancel_and_count(output int busy_cycles);
        Cancel_Pulse = 1'b1;
        step();
        Cancel_Pulse = 1'b0;
        busy_cycles = 0;
        while (Busy && busy_cycles < 20) begin
            busy_cycles++;
            step();
        end
    endtask

    task automatic chk_line(input string name, input int idx, input int id, input int qty);
        Rd_Idx = 3'(idx);
        #1;
        chk({name, "_id"}, int'(Rd_ProductID), id);
        chk({name, "_qty"}, int'(Rd_Quantity), qty);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, rej;
        int   bc;

        //        add id q  can dp dir clr rd   cnt hl bsy ack rej rid rq
        vecs.push_back(mk(1, 3, 2, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3, 2));
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 1, 0, 5, 1));
        vecs.push_back(mk(1, 5, 4, 0, 0, 0, 0, 1,  2, 0, 1, 0, 0, 5, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  2, 0, 1, 0, 0, 5, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 1, 0, 5, 5));
        vecs.push_back(mk(1, 5, 4, 0, 0, 0, 0, 1,  2, 0, 1, 0, 0, 5, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  2, 0, 1, 0, 0, 5, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 1, 0, 5, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2,  2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 3, 2));
        vecs.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 3, 2));
        vecs.push_back(mk(1, 9, 1, 1, 0, 0, 0, 0,  2, 0, 1, 0, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2,  3, 0, 0, 1, 0, 6, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2,  3, 0, 0, 0, 0, 6, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0,  3, 1, 0, 0, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0,  3, 1, 0, 0, 0, 3, 2));
        vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0,  3, 1, 1, 0, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 3, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));

        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        chk("reset_count", int'(Entry_Count), 0);
        chk("reset_highlight", int'(Highlight_Idx), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_empty", int'(Empty), 1);
        chk("reset_full", int'(Full), 0);
        chk("reset_ack", int'(Add_Ack), 0);
        chk("reset_reject", int'(Add_Reject), 0);

        foreach (vecs[i]) begin
            Add_Pulse = vecs[i].add; Add_ProductID = 4'(vecs[i].id);
            Add_Quantity = 3'(vecs[i].qty); Cancel_Pulse = vecs[i].cancel;
            Dir_Pulse = vecs[i].dirp; Dir_in = 2'(vecs[i].dir);
            Clear_Pulse = vecs[i].clr; Rd_Idx = 3'(vecs[i].rd);
            step();
            chk($sformatf("v%0d_count", i), int'(Entry_Count), vecs[i].e_cnt);
            chk($sformatf("v%0d_highlight", i), int'(Highlight_Idx), vecs[i].e_hl);
            chk($sformatf("v%0d_busy", i), int'(Busy), int'(vecs[i].e_busy));
            chk($sformatf("v%0d_ack", i), int'(Add_Ack), int'(vecs[i].e_ack));
            chk($sformatf("v%0d_reject", i), int'(Add_Reject), int'(vecs[i].e_rej));
            chk($sformatf("v%0d_rd_id", i), int'(Rd_ProductID), vecs[i].e_rid);
            chk($sformatf("v%0d_rd_qty", i), int'(Rd_Quantity), vecs[i].e_rqty);
        end
        idle_inputs();

        // Cancel in the middle of a four-line basket, then cursor limits.
        for (int id = 1; id <= 4; id++) begin
            do_add(id, 1, ack, rej);
            chk($sformatf("build4_ack_%0d", id), int'(ack), 1);
        end
        dir_step(2'b10);
        chk("pre_cancel_highlight", int'(Highlight_Idx), 1);
        cancel_and_count(bc);
        chk("cancel_busy_cycles", bc, 3);
        chk("cancel_count", int'(Entry_Count), 3);
        chk("cancel_highlight", int'(Highlight_Idx), 1);
        chk_line("cancel_l0", 0, 1, 1);
        chk_line("cancel_l1", 1, 3, 1);
        chk_line("cancel_l2", 2, 4, 1);
        chk_line("cancel_l3", 3, 0, 0);
        for (int n = 0; n < 5; n++) dir_step(2'b10);
        chk("dir_down_sat", int'(Highlight_Idx), 2);
        for (int n = 0; n < 5; n++) dir_step(2'b01);
        chk("dir_up_sat", int'(Highlight_Idx), 0);

        // Cancelling the last line pulls the cursor back onto the new last line.
        dir_step(2'b10);
        dir_step(2'b10);
        cancel_and_count(bc);
        chk("cancel_last_busy_cycles", bc, 1);
        chk("cancel_last_count", int'(Entry_Count), 2);
        chk("cancel_last_highlight", int'(Highlight_Idx), 1);
        chk_line("cancel_last_l1", 1, 3, 1);

        // Fill to capacity, then one more distinct product is refused.
        Clear_Pulse = 1'b1;
        step();
        Clear_Pulse = 1'b0;
        chk("clear_count", int'(Entry_Count), 0);
        for (int id = 1; id <= 8; id++) begin
            do_add(id, 1, ack, rej);
            chk($sformatf("fill_ack_%0d", id), int'(ack), 1);
        end
        chk("fill_count", int'(Entry_Count), 8);
        chk("fill_full", int'(Full), 1);
        chk("fill_empty", int'(Empty), 0);
        do_add(9, 1, ack, rej);
        chk("full_reject", int'(rej), 1);
        chk("full_no_ack", int'(ack), 0);
        step();
        chk("full_reject_one_cycle", int'(Add_Reject), 0);
        chk("full_count_kept", int'(Entry_Count), 8);
        chk_line("full_l7", 7, 8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
